// File: rtl/pipeline_stall_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stall_controller_pkg
// Description : Shared LC-3b pipeline types for the stall controller: the
//               machine word, the controller state encoding and the NOP
//               instruction word that flushed pipeline registers carry.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_stall_controller_pkg;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        S_RUN        = 2'd0,
        S_DMEM_WAIT  = 2'd1,
        S_LU_BUBBLE  = 2'd2,
        S_REDIR_PEND = 2'd3
    } lc3b_pipe_state_t;

    // BR with no condition bits set never branches, so all-zero is a NOP.
    localparam lc3b_word c_lc3b_nop = 16'h0000;

endpackage
`default_nettype wire

// File: rtl/pipeline_stall_controller_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that holds at all-ones, with synchronous clear.
// Ports       : clk, rst    - clock, synchronous active-high reset
//               inc         - count one event this cycle
//               clr         - return to zero (wins over inc)
//               q           - current count
//               at_max      - count is all-ones
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q,
    output logic         at_max
);

    logic [W-1:0] r_q;

    assign q      = r_q;
    assign at_max = &r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && !at_max) begin
            r_q <= r_q + W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stall_controller
// Description : Central sequencer of the 5-stage LC-3b pipeline. Turns D-cache
//               waits, taken-branch redirects, load-use hazards and I-cache
//               waits (in that priority) into per-stage load enables and
//               NOP-insertion controls, holds a redirect across an in-flight
//               fetch, and keeps saturating stall/flush counters plus a sticky
//               D-cache timeout flag.
// Ports       : clk, rst                      - clock, sync active-high reset
//               ld_use_hazard                 - load in EX/MEM feeds EX
//               icache_read / icache_resp     - fetch outstanding / done
//               dcache_req / dcache_resp      - MEM access outstanding / done
//               br_redirect / br_target       - taken branch from MEM
//               load_pc .. load_mem_wb        - stage register enables
//               flush_if_id, flush_id_ex,
//               bubble_ex_mem                 - load NOP into that register
//               pc_redirect / _target         - PC mux select and address
//               stall_count, flush_count      - performance counters
//               mem_timeout                   - sticky D-cache wait overrun
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int PERF_W       = 16,
    parameter int DMEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_use_hazard,
    input  logic              icache_read,
    input  logic              icache_resp,
    input  logic              dcache_req,
    input  logic              dcache_resp,
    input  logic              br_redirect,
    input  logic [15:0]       br_target,
    output logic              load_pc,
    output logic              load_if_id,
    output logic              load_id_ex,
    output logic              load_ex_mem,
    output logic              load_mem_wb,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              bubble_ex_mem,
    output logic              pc_redirect,
    output logic [15:0]       pc_redirect_target,
    output logic [PERF_W-1:0] stall_count,
    output logic [PERF_W-1:0] flush_count,
    output logic              mem_timeout
);

    localparam int c_WAIT_W = $clog2(DMEM_TIMEOUT + 1);

    lc3b_pipe_state_t r_state;
    lc3b_pipe_state_t w_next_state;
    lc3b_word         r_target;
    logic             r_mem_timeout;

    logic                w_frozen;
    logic                w_fetch_busy;
    logic                w_redir_accept;
    logic                w_stall_sat;
    logic                w_flush_sat;
    logic                w_wait_sat;
    logic [c_WAIT_W-1:0] w_wait_q;

    assign w_frozen     = dcache_req & ~dcache_resp;
    assign w_fetch_busy = icache_read & ~icache_resp;
    assign mem_timeout  = r_mem_timeout;

    always_comb begin
        w_next_state       = r_state;
        w_redir_accept     = 1'b0;
        load_pc            = 1'b1;
        load_if_id         = 1'b1;
        load_id_ex         = 1'b1;
        load_ex_mem        = 1'b1;
        load_mem_wb        = 1'b1;
        flush_if_id        = 1'b0;
        flush_id_ex        = 1'b0;
        bubble_ex_mem      = 1'b0;
        pc_redirect        = 1'b0;
        pc_redirect_target = r_target;

        if (w_frozen) begin
            // Full freeze. A pending redirect survives the freeze in its own
            // state so the latched target is not lost.
            load_pc     = 1'b0;
            load_if_id  = 1'b0;
            load_id_ex  = 1'b0;
            load_ex_mem = 1'b0;
            load_mem_wb = 1'b0;
            if (r_state != S_REDIR_PEND) begin
                w_next_state = S_DMEM_WAIT;
            end
        end else if (r_state == S_REDIR_PEND) begin
            // Wrong-path fetch data is discarded; newer br_redirect ignored.
            flush_if_id = 1'b1;
            if (w_fetch_busy) begin
                load_pc = 1'b0;
            end else begin
                pc_redirect  = 1'b1;
                w_next_state = S_RUN;
            end
        end else if (br_redirect) begin
            flush_if_id    = 1'b1;
            flush_id_ex    = 1'b1;
            bubble_ex_mem  = 1'b1;
            w_redir_accept = 1'b1;
            if (w_fetch_busy) begin
                w_next_state = S_REDIR_PEND;
            end else begin
                pc_redirect        = 1'b1;
                pc_redirect_target = br_target;
                w_next_state       = S_RUN;
            end
        end else if (ld_use_hazard && (r_state == S_RUN)) begin
            load_pc       = 1'b0;
            load_if_id    = 1'b0;
            load_id_ex    = 1'b0;
            bubble_ex_mem = 1'b1;
            w_next_state  = S_LU_BUBBLE;
        end else begin
            w_next_state = S_RUN;
            if (w_fetch_busy) begin
                load_pc     = 1'b0;
                flush_if_id = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_RUN;
            r_target      <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_redir_accept) begin
                r_target <= br_target;
            end
            // Set on the edge that brings the wait count to DMEM_TIMEOUT.
            if (w_frozen && (w_wait_q == c_WAIT_W'(DMEM_TIMEOUT - 1))) begin
                r_mem_timeout <= 1'b1;
            end
        end
    end

    sat_counter #(.W(PERF_W)) u_stall_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (~load_pc & ~w_stall_sat),
        .clr    (1'b0),
        .q      (stall_count),
        .at_max (w_stall_sat)
    );

    sat_counter #(.W(PERF_W)) u_flush_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (w_redir_accept & ~w_flush_sat),
        .clr    (1'b0),
        .q      (flush_count),
        .at_max (w_flush_sat)
    );

    sat_counter #(.W(c_WAIT_W)) u_wait_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (w_frozen & ~w_wait_sat),
        .clr    (~w_frozen),
        .q      (w_wait_q),
        .at_max (w_wait_sat)
    );

endmodule
`default_nettype wire
